riscv_run_controller: RTL and testbench

//  Sequences the 8-bit pipelined RISC-V core through clear -> program load -> run -> halt.

---
 rtl/riscv_run_controller.sv | 182 ++++++++++++++++++
 tb/tb_riscv_run_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_controller.sv
// riscv_run_controller
//   Sequences the 8-bit pipelined RISC-V core through one session:
//   wipe the IF instruction memory, stream a program into it, release the
//   core for a bounded run, then hold it in reset and keep the run summary.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   start                 begin a session (honoured in IDLE/DONE only)
//   prog_valid/ready      program word handshake; prog_last marks final word
//   prog_data             instruction word to load
//   halt_req              abort LOAD or stop RUN
//   write_reg_data        core write-back data, sampled every RUN cycle
//   rw, PC_write,
//   instruction_in        IF memory write port (one-cycle write strobe)
//   reset_IF_memory       IF memory clear, held for CLEAR_CYCLES
//   core_reset            active-high core pipeline reset
//   busy, done, overflow  session status
//   run_cycles            cycles spent with the core out of reset
//   last_wb_data          write-back data from the final RUN cycle
//
// state  | meaning
// IDLE   | after reset, core held in reset, waiting for start
// CLEAR  | reset_IF_memory asserted for CLEAR_CYCLES cycles
// LOAD   | accepting program words, each written the cycle after handshake
// SETTLE | final word lands in IF memory, core still held in reset
// RUN    | core released, cycles counted, write-back data captured
// DONE   | core held in reset, results held until the next start

module riscv_run_controller #(
    parameter int PC_SIZE        = 10,
    parameter int ADDR_STEP      = 4,
    parameter int CLEAR_CYCLES   = 2,
    parameter int MAX_RUN_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               prog_valid,
    output logic               prog_ready,
    input  logic [31:0]        prog_data,
    input  logic               prog_last,
    input  logic               halt_req,
    input  logic [7:0]         write_reg_data,
    output logic               rw,
    output logic               reset_IF_memory,
    output logic [PC_SIZE-1:0] PC_write,
    output logic [31:0]        instruction_in,
    output logic               core_reset,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [15:0]        run_cycles,
    output logic [7:0]         last_wb_data
);

    localparam int                 CLR_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]   CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [15:0]        RUN_LOAD = 16'(MAX_RUN_CYCLES - 1);
    localparam logic [PC_SIZE-1:0] ADDR_INC = PC_SIZE'(ADDR_STEP);
    localparam logic [PC_SIZE-1:0] ADDR_TOP = PC_SIZE'((1 << PC_SIZE) - ADDR_STEP);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RUN    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t             state;
    logic [PC_SIZE-1:0] addr;
    logic [CLR_W-1:0]   clr_left;
    logic [15:0]        run_left;
    logic               accept;
    logic               top_hit;

    assign accept  = (state == ST_LOAD) && prog_valid && prog_ready;
    // Last slot of the address space taken by a word that does not end the program.
    assign top_hit = accept && !prog_last && (addr == ADDR_TOP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            addr            <= '0;
            clr_left        <= '0;
            run_left        <= '0;
            prog_ready      <= 1'b0;
            rw              <= 1'b0;
            reset_IF_memory <= 1'b0;
            PC_write        <= '0;
            instruction_in  <= '0;
            core_reset      <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            overflow        <= 1'b0;
            run_cycles      <= '0;
            last_wb_data    <= '0;
        end else begin
            rw <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state           <= ST_CLEAR;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        overflow        <= 1'b0;
                        run_cycles      <= '0;
                        last_wb_data    <= '0;
                        reset_IF_memory <= 1'b1;
                        PC_write        <= '0;
                        addr            <= '0;
                        clr_left        <= CLR_LOAD;
                    end
                end

                ST_CLEAR: begin
                    if (clr_left == '0) begin
                        state           <= ST_LOAD;
                        reset_IF_memory <= 1'b0;
                        prog_ready      <= 1'b1;
                    end else begin
                        clr_left <= clr_left - 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (accept) begin
                        rw             <= 1'b1;
                        PC_write       <= addr;
                        instruction_in <= prog_data;
                        // Top slot never advances the counter, so it cannot wrap.
                        if (addr != ADDR_TOP) begin
                            addr <= addr + ADDR_INC;
                        end
                    end
                    if (halt_req || top_hit) begin
                        if (top_hit) begin
                            overflow <= 1'b1;
                        end
                        state      <= ST_DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        prog_ready <= 1'b0;
                    end else if (accept && prog_last) begin
                        state      <= ST_SETTLE;
                        prog_ready <= 1'b0;
                    end
                end

                ST_SETTLE: begin
                    state      <= ST_RUN;
                    core_reset <= 1'b0;
                    run_left   <= RUN_LOAD;
                end

                ST_RUN: begin
                    if (run_cycles != 16'hFFFF) begin
                        run_cycles <= run_cycles + 16'd1;
                    end
                    last_wb_data <= write_reg_data;
                    if (halt_req || (run_left == '0)) begin
                        state      <= ST_DONE;
                        core_reset <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        run_left <= run_left - 16'd1;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    core_reset <= 1'b1;
                    busy       <= 1'b0;
                    prog_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_run_controller.sv
// Directed bench for riscv_run_controller with a small address space
// (PC_SIZE=4) and a short run limit (MAX_RUN_CYCLES=5).

module tb_riscv_run_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        prog_valid = 1'b0;
    logic        prog_ready;
    logic [31:0] prog_data = '0;
    logic        prog_last = 1'b0;
    logic        halt_req = 1'b0;
    logic [7:0]  write_reg_data = '0;
    logic        rw;
    logic        reset_IF_memory;
    logic [3:0]  PC_write;
    logic [31:0] instruction_in;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] run_cycles;
    logic [7:0]  last_wb_data;

    int total = 0;
    int bad   = 0;

    riscv_run_controller #(
        .PC_SIZE(4),
        .ADDR_STEP(4),
        .CLEAR_CYCLES(2),
        .MAX_RUN_CYCLES(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .prog_valid(prog_valid),
        .prog_ready(prog_ready),
        .prog_data(prog_data),
        .prog_last(prog_last),
        .halt_req(halt_req),
        .write_reg_data(write_reg_data),
        .rw(rw),
        .reset_IF_memory(reset_IF_memory),
        .PC_write(PC_write),
        .instruction_in(instruction_in),
        .core_reset(core_reset),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .run_cycles(run_cycles),
        .last_wb_data(last_wb_data)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        step();
        step();
        total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL rst_core_reset: got %b want 1", core_reset); end
        total++; if ({rw, prog_ready, reset_IF_memory, busy, done, overflow} !== 6'b0) begin
            bad++; $display("FAIL rst_flags: got %b want 000000", {rw, prog_ready, reset_IF_memory, busy, done, overflow});
        end
        total++; if ({PC_write, instruction_in, run_cycles, last_wb_data} !== 60'd0) begin
            bad++; $display("FAIL rst_data: got %h want 0", {PC_write, instruction_in, run_cycles, last_wb_data});
        end
        reset = 1'b1;
        // prog_valid in IDLE must never produce a write
        prog_valid = 1'b1;
        prog_data  = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (rw !== 1'b0 || prog_ready !== 1'b0 || core_reset !== 1'b1) begin
                bad++; $display("FAIL idle_valid[%0d]: got rw=%b rdy=%b cr=%b want 0 0 1", i, rw, prog_ready, core_reset);
            end
        end
        prog_valid = 1'b0;
    endtask

    task automatic test_load_three();
        logic [31:0] words [3];
        logic [3:0]  exp_pc [3];
        words  = '{32'h00A00093, 32'h00108113, 32'h002101B3};
        exp_pc = '{4'd0, 4'd4, 4'd8};
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if ({reset_IF_memory, busy, core_reset, prog_ready} !== 4'b1110) begin
            bad++; $display("FAIL clr1: got rim/busy/cr/rdy=%b want 1110", {reset_IF_memory, busy, core_reset, prog_ready});
        end
        step();
        total++; if (reset_IF_memory !== 1'b1) begin bad++; $display("FAIL clr2_rim: got %b want 1", reset_IF_memory); end
        step();
        total++; if (reset_IF_memory !== 1'b0 || prog_ready !== 1'b1) begin
            bad++; $display("FAIL load_entry: got rim=%b rdy=%b want 0 1", reset_IF_memory, prog_ready);
        end
        for (int i = 0; i < 3; i++) begin
            prog_valid = 1'b1;
            prog_data  = words[i];
            prog_last  = (i == 2);
            step();
            total++; if (rw !== 1'b1 || PC_write !== exp_pc[i] || instruction_in !== words[i]) begin
                bad++; $display("FAIL load_word[%0d]: got rw=%b pc=%0d d=%h want 1 %0d %h", i, rw, PC_write, instruction_in, exp_pc[i], words[i]);
            end
            total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL load_cr[%0d]: got %b want 1", i, core_reset); end
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        total++; if (prog_ready !== 1'b0) begin bad++; $display("FAIL settle_rdy: got %b want 0", prog_ready); end
        step();
        total++; if (core_reset !== 1'b0 || rw !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL run_entry: got cr=%b rw=%b busy=%b want 0 0 1", core_reset, rw, busy);
        end
    endtask

    task automatic test_run_limit();
        int low_cnt;
        low_cnt = (core_reset === 1'b0) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            write_reg_data = 8'(16 + i);
            step();
            if (core_reset === 1'b0) low_cnt++;
            else break;
        end
        total++; if (low_cnt != 5) begin bad++; $display("FAIL limit_low_cycles: got %0d want 5", low_cnt); end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL limit_done: got done=%b busy=%b want 1 0", done, busy); end
        total++; if (run_cycles !== 16'd5) begin bad++; $display("FAIL limit_run_cycles: got %0d want 5", run_cycles); end
        total++; if (last_wb_data !== 8'h14) begin bad++; $display("FAIL limit_last_wb: got %h want 14", last_wb_data); end
        write_reg_data = 8'hEE;
        step();
        total++; if (done !== 1'b1 || core_reset !== 1'b1 || last_wb_data !== 8'h14) begin
            bad++; $display("FAIL done_hold: got done=%b cr=%b wb=%h want 1 1 14", done, core_reset, last_wb_data);
        end
    endtask

    task automatic test_halt_restart();
        start    = 1'b1;
        halt_req = 1'b1;
        step();
        start = 1'b0;
        total++; if ({done, overflow, reset_IF_memory} !== 3'b001 || run_cycles !== 16'd0 || last_wb_data !== 8'd0) begin
            bad++; $display("FAIL restart_clear: got d/o/rim=%b rc=%0d wb=%h want 001 0 00", {done, overflow, reset_IF_memory}, run_cycles, last_wb_data);
        end
        step();
        step();
        total++; if (prog_ready !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL halt_in_clear: got rdy=%b done=%b want 1 0", prog_ready, done);
        end
        halt_req   = 1'b0;
        prog_valid = 1'b1;
        prog_last  = 1'b1;
        prog_data  = 32'h00000013;
        step();
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        step();
        write_reg_data = 8'hA1;
        step();
        write_reg_data = 8'hA2;
        step();
        total++; if (run_cycles !== 16'd2 || core_reset !== 1'b0) begin
            bad++; $display("FAIL halt_mid_run: got rc=%0d cr=%b want 2 0", run_cycles, core_reset);
        end
        write_reg_data = 8'hA3;
        halt_req       = 1'b1;
        step();
        halt_req = 1'b0;
        total++; if (done !== 1'b1 || core_reset !== 1'b1 || run_cycles !== 16'd3 || last_wb_data !== 8'hA3) begin
            bad++; $display("FAIL halt_stop: got done=%b cr=%b rc=%0d wb=%h want 1 1 3 a3", done, core_reset, run_cycles, last_wb_data);
        end
    endtask

    task automatic test_overflow();
        logic       exp_rw [5];
        logic [3:0] exp_pc [5];
        exp_rw = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_pc = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd0};
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        prog_valid = 1'b1;
        prog_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            prog_data = 32'hC0DE0000 + 32'(i);
            step();
            total++; if (rw !== exp_rw[i] || core_reset !== 1'b1) begin
                bad++; $display("FAIL ovf_rw[%0d]: got rw=%b cr=%b want %b 1", i, rw, core_reset, exp_rw[i]);
            end
            if (exp_rw[i]) begin
                total++; if (PC_write !== exp_pc[i]) begin bad++; $display("FAIL ovf_pc[%0d]: got %0d want %0d", i, PC_write, exp_pc[i]); end
            end
        end
        prog_valid = 1'b0;
        total++; if (instruction_in !== 32'hC0DE0003) begin bad++; $display("FAIL ovf_top_data: got %h want c0de0003", instruction_in); end
        total++; if (overflow !== 1'b1 || done !== 1'b1 || prog_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL ovf_flags: got o/d/rdy/busy=%b want 1100", {overflow, done, prog_ready, busy});
        end
        step();
        total++; if (rw !== 1'b0 || core_reset !== 1'b1) begin bad++; $display("FAIL ovf_after: got rw=%b cr=%b want 0 1", rw, core_reset); end
    endtask

    task automatic test_gaps();
        logic       pv [7];
        logic [3:0] exp_pc [7];
        pv     = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_pc = '{4'd0, 4'd0, 4'd4, 4'd8, 4'd0, 4'd0, 4'd12};
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL gap_ovf_cleared: got %b want 0", overflow); end
        step();
        step();
        for (int i = 0; i < 7; i++) begin
            prog_valid = pv[i];
            prog_last  = (i == 6);
            prog_data  = 32'h00005000 + 32'(i);
            start      = (i == 4);
            step();
            total++; if (rw !== pv[i] || reset_IF_memory !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL gap_rw[%0d]: got rw=%b rim=%b busy=%b want %b 0 1", i, rw, reset_IF_memory, busy, pv[i]);
            end
            if (pv[i]) begin
                total++; if (PC_write !== exp_pc[i] || instruction_in !== 32'h00005000 + 32'(i)) begin
                    bad++; $display("FAIL gap_pc[%0d]: got pc=%0d d=%h want %0d %h", i, PC_write, instruction_in, exp_pc[i], 32'h00005000 + 32'(i));
                end
            end
        end
        start      = 1'b0;
        prog_last  = 1'b0;
        prog_valid = 1'b1;
        total++; if (overflow !== 1'b0 || prog_ready !== 1'b0) begin
            bad++; $display("FAIL gap_top_last: got ovf=%b rdy=%b want 0 0", overflow, prog_ready);
        end
        step();
        total++; if (rw !== 1'b0 || core_reset !== 1'b0) begin bad++; $display("FAIL gap_run_valid: got rw=%b cr=%b want 0 0", rw, core_reset); end
        halt_req = 1'b1;
        step();
        halt_req   = 1'b0;
        prog_valid = 1'b0;
        total++; if (done !== 1'b1 || rw !== 1'b0 || run_cycles !== 16'd1) begin
            bad++; $display("FAIL gap_done: got done=%b rw=%b rc=%0d want 1 0 1", done, rw, run_cycles);
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        prog_valid = 1'b1;
        prog_data  = 32'h12345678;
        step();
        total++; if (rw !== 1'b1) begin bad++; $display("FAIL areset_pre_load: got rw=%b want 1", rw); end
        #2 reset = 1'b0;
        #1;
        total++; if ({core_reset, rw, prog_ready, busy} !== 4'b1000) begin
            bad++; $display("FAIL areset_load: got cr/rw/rdy/busy=%b want 1000", {core_reset, rw, prog_ready, busy});
        end
        prog_valid = 1'b0;
        #2 reset = 1'b1;
        step();
        total++; if (busy !== 1'b0 || prog_ready !== 1'b0) begin bad++; $display("FAIL areset_idle: got busy=%b rdy=%b want 0 0", busy, prog_ready); end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        prog_valid = 1'b1;
        prog_last  = 1'b1;
        step();
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        step();
        write_reg_data = 8'h77;
        step();
        total++; if (core_reset !== 1'b0 || run_cycles !== 16'd1) begin
            bad++; $display("FAIL areset_pre_run: got cr=%b rc=%0d want 0 1", core_reset, run_cycles);
        end
        #2 reset = 1'b0;
        #1;
        total++; if ({core_reset, rw, prog_ready, busy, done} !== 5'b10000 || run_cycles !== 16'd0 || last_wb_data !== 8'd0) begin
            bad++; $display("FAIL areset_run: got flags=%b rc=%0d wb=%h want 10000 0 00", {core_reset, rw, prog_ready, busy, done}, run_cycles, last_wb_data);
        end
        #2 reset = 1'b1;
        step();
        step();
        total++; if (core_reset !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL areset_stay_idle: got cr=%b busy=%b want 1 0", core_reset, busy); end
    endtask

    initial begin
        test_reset();
        test_load_three();
        test_run_limit();
        test_halt_restart();
        test_overflow();
        test_gaps();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
